// File: rtl/even_par_check.sv
// Even-parity checker with registered result, sticky error flag and
// optional saturating error counter (enable with EVEN_PAR_CHECK_COUNT_EN).
module even_par_check #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              even_parity,
  input  logic              clr,
  output logic              ep_check_comb,
  output logic              ep_check,
  output logic              out_valid,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count
);

  logic chk_q, chk_d;
  logic vld_q, vld_d;
  logic stk_q, stk_d;
  logic err_ev;

  assign ep_check_comb = ^{even_parity, data};
  assign err_ev        = in_valid & ep_check_comb;

  always_comb begin
    chk_d = chk_q;
    vld_d = in_valid;
    stk_d = stk_q;
    if (in_valid) chk_d = ep_check_comb;
    // clr wins over a same-cycle error
    if (clr)         stk_d = 1'b0;
    else if (err_ev) stk_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= 1'b0;
      vld_q <= 1'b0;
      stk_q <= 1'b0;
    end else begin
      chk_q <= chk_d;
      vld_q <= vld_d;
      stk_q <= stk_d;
    end
  end

  assign ep_check   = chk_q;
  assign out_valid  = vld_q;
  assign err_sticky = stk_q;

`ifdef EVEN_PAR_CHECK_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (err_ev && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_even_par_check.sv
// Directed bench for even_par_check: default instance plus a
// CNT_W=2 instance sharing the same stimulus for saturation checks.
module tb_even_par_check;

`ifdef EVEN_PAR_CHECK_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] data;
  logic       even_parity;
  logic       clr;

  logic       comb_a, chk_a, vld_a, stk_a;
  logic [7:0] cnt_a;
  logic       comb_b, chk_b, vld_b, stk_b;
  logic [1:0] cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  even_par_check #(.DATA_W(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data(data),
    .even_parity(even_parity), .clr(clr),
    .ep_check_comb(comb_a), .ep_check(chk_a), .out_valid(vld_a),
    .err_sticky(stk_a), .err_count(cnt_a)
  );

  even_par_check #(.DATA_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data(data),
    .even_parity(even_parity), .clr(clr),
    .ep_check_comb(comb_b), .ep_check(chk_b), .out_valid(vld_b),
    .err_sticky(stk_b), .err_count(cnt_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; data = 4'h0;
    even_parity = 1'b0; clr = 1'b0;
    #1;
    total++;
    if ({chk_a, vld_a, stk_a, cnt_a} !== 11'd0) begin
      bad++;
      $display("FAIL reset_a: got %b want 0", {chk_a, vld_a, stk_a, cnt_a});
    end
    total++;
    if ({chk_b, vld_b, stk_b, cnt_b} !== 5'd0) begin
      bad++;
      $display("FAIL reset_b: got %b want 0", {chk_b, vld_b, stk_b, cnt_b});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sweep();
    logic [4:0] v;
    logic       p;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      p = ^v;
      in_valid = 1'b1; even_parity = v[4]; data = v[3:0];
      #1;
      total++;
      if (comb_a !== p) begin
        bad++;
        $display("FAIL sweep_comb i=%0d: got %b want %b", i, comb_a, p);
      end
      step();
      total++;
      if (chk_a !== p || vld_a !== 1'b1) begin
        bad++;
        $display("FAIL sweep_chk i=%0d: got chk=%b vld=%b want %b/1",
                 i, chk_a, vld_a, p);
      end
    end
    in_valid = 1'b0;
    total++;
    if (cnt_a !== (CNT_EN ? 8'd16 : 8'd0) || stk_a !== 1'b1) begin
      bad++;
      $display("FAIL sweep_cnt: got cnt=%0d stk=%b want %0d/1",
               cnt_a, stk_a, CNT_EN ? 16 : 0);
    end
    total++;
    if (cnt_b !== (CNT_EN ? 2'd3 : 2'd0)) begin
      bad++;
      $display("FAIL sweep_sat: got %0d want %0d", cnt_b, CNT_EN ? 3 : 0);
    end
  endtask

  task automatic test_example();
    in_valid = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    in_valid = 1'b1; data = 4'b1011; even_parity = 1'b1;
    #1;
    total++;
    if (comb_a !== 1'b0) begin
      bad++;
      $display("FAIL ex_comb: got %b want 0", comb_a);
    end
    step();
    total++;
    if (chk_a !== 1'b0 || vld_a !== 1'b1 || stk_a !== 1'b0) begin
      bad++;
      $display("FAIL ex_good: got chk=%b vld=%b stk=%b want 0/1/0",
               chk_a, vld_a, stk_a);
    end
    even_parity = 1'b0;
    step();
    total++;
    if (chk_a !== 1'b1 || vld_a !== 1'b1 || stk_a !== 1'b1) begin
      bad++;
      $display("FAIL ex_bad: got chk=%b vld=%b stk=%b want 1/1/1",
               chk_a, vld_a, stk_a);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_b [5];
    exp_b = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clr = 1'b1;
    step();
    clr = 1'b0;
    in_valid = 1'b1; data = 4'b0001; even_parity = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (cnt_b !== (CNT_EN ? exp_b[k] : 2'd0)) begin
        bad++;
        $display("FAIL sat k=%0d: got %0d want %0d", k, cnt_b,
                 CNT_EN ? exp_b[k] : 2'd0);
      end
      total++;
      if (cnt_a !== (CNT_EN ? 8'(k + 1) : 8'd0)) begin
        bad++;
        $display("FAIL cnt k=%0d: got %0d want %0d", k, cnt_a,
                 CNT_EN ? k + 1 : 0);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_clr_priority();
    clr = 1'b1; in_valid = 1'b1; data = 4'b0111; even_parity = 1'b0;
    step();
    clr = 1'b0; in_valid = 1'b0;
    total++;
    if (cnt_a !== 8'd0 || stk_a !== 1'b0 || cnt_b !== 2'd0 ||
        stk_b !== 1'b0) begin
      bad++;
      $display("FAIL clr_prio: got cnt=%0d stk=%b want 0/0", cnt_a, stk_a);
    end
    total++;
    if (chk_a !== 1'b1 || vld_a !== 1'b1) begin
      bad++;
      $display("FAIL clr_chk: got chk=%b vld=%b want 1/1", chk_a, vld_a);
    end
  endtask

  task automatic test_idle_hold();
    in_valid = 1'b1; data = 4'b1000; even_parity = 1'b0;
    step();
    in_valid = 1'b0; data = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (vld_a !== 1'b0 || chk_a !== 1'b1 ||
          cnt_a !== (CNT_EN ? 8'd1 : 8'd0) || stk_a !== 1'b1) begin
        bad++;
        $display("FAIL idle k=%0d: got vld=%b chk=%b cnt=%0d stk=%b",
                 k, vld_a, chk_a, cnt_a, stk_a);
      end
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; data = 4'b1110; even_parity = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({chk_a, vld_a, stk_a, cnt_a} !== 11'd0 ||
        {chk_b, vld_b, stk_b, cnt_b} !== 5'd0) begin
      bad++;
      $display("FAIL async_rst: got %b %b want 0",
               {chk_a, vld_a, stk_a, cnt_a}, {chk_b, vld_b, stk_b, cnt_b});
    end
    #3;
    rst_n = 1'b1;
    step();
    total++;
    if (chk_a !== 1'b1 || vld_a !== 1'b1 || stk_a !== 1'b1 ||
        cnt_a !== (CNT_EN ? 8'd1 : 8'd0)) begin
      bad++;
      $display("FAIL post_rst: got chk=%b vld=%b stk=%b cnt=%0d",
               chk_a, vld_a, stk_a, cnt_a);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_example();
    test_saturate();
    test_clr_priority();
    test_idle_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
